exe_mc_ctrl: RTL

Sequencer for multi-cycle execute operations (M-extension mul/div) in the five-stage pipeline. It accepts a multi-cycle instruction from decode, starts the iterative unit and stalls the front of the pipeline. It captures the unit's result and presents it for one cycle to the execute-stage output register, which muxes it onto the normal rd path. It also generates the load-use bubble and handles flush and unit timeout.

---
 rtl/exe_mc_ctrl_if.sv | 25 ++
 rtl/exe_mc_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/exe_mc_ctrl_if.sv
// Handshake between the multi-cycle execute sequencer and the iterative mul/div unit.
// The sequencer is the master: it starts and kills operations, and the unit returns
// a one-cycle done pulse together with its result.
interface exe_mc_ctrl_if #(
    parameter int XLEN = 32
);
    logic            mc_start;
    logic            mc_kill;
    logic            mc_done;
    logic [XLEN-1:0] mc_result;

    modport master (
        output mc_start,
        output mc_kill,
        input  mc_done,
        input  mc_result
    );

    modport slave (
        input  mc_start,
        input  mc_kill,
        output mc_done,
        output mc_result
    );
endinterface

// File: rtl/exe_mc_ctrl.sv
// Multi-cycle execute sequencer: accepts a mul/div from decode, drives the iterative
// unit, stalls the front end while it runs, and presents the captured result for one
// cycle to the execute output register. Also raises the load-use bubble and aborts a
// unit that never answers.
module exe_mc_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            id_valid_i,
    input  logic            id_mc_i,
    input  logic [4:0]      id_rd_addr_i,
    input  logic            id_rd_we_i,
    input  logic [4:0]      id_rs1_addr_i,
    input  logic [4:0]      id_rs2_addr_i,
    input  logic            ex_is_load_i,
    input  logic [4:0]      ex_rd_addr_i,
    input  logic            flush_i,
    exe_mc_ctrl_if.master   mc,
    output logic            stall_o,
    output logic            wb_valid_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            rd_we_o,
    output logic            mc_err_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              rd_we_q;
    logic [4:0]        rd_addr_q;
    logic [XLEN-1:0]   rd_data_q;

    logic              accept;
    logic              lu_hazard;
    logic              cnt_last;
    logic              start_int;
    logic              kill_int;
    logic              err_int;
    logic              wb_int;
    logic              we_int;

    // The counter is cleared in START, so it tops out at TIMEOUT-1 and never wraps.
    assign cnt_last  = (cnt_q == CNT_W'(TIMEOUT - 1));

    assign accept    = (state_q == IDLE) & id_valid_i & id_mc_i & ~flush_i;

    // Load-use bubble only matters while idle; x0 is never a real dependency.
    assign lu_hazard = (state_q == IDLE) & ex_is_load_i & (ex_rd_addr_i != 5'd0) & id_valid_i &
                       ((ex_rd_addr_i == id_rs1_addr_i) | (ex_rd_addr_i == id_rs2_addr_i));

    assign stall_o   = (state_q != IDLE) | accept | lu_hazard;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; in BUSY a flush beats done, and done beats the timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                end
            end
            START: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (mc.mc_done) begin
                    state_d = WB;
                end else if (cnt_last) begin
                    state_d = IDLE;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from registered state plus same-cycle flush/done/counter
    always_comb begin
        start_int = 1'b0;
        kill_int  = 1'b0;
        err_int   = 1'b0;
        wb_int    = 1'b0;
        we_int    = 1'b0;
        case (state_q)
            START: begin
                start_int = 1'b1;
                kill_int  = flush_i;
            end
            BUSY: begin
                if (flush_i) begin
                    kill_int = 1'b1;
                end else if (!mc.mc_done && cnt_last) begin
                    kill_int = 1'b1;
                    err_int  = 1'b1;
                end
            end
            WB: begin
                wb_int = 1'b1;
                we_int = rd_we_q & ~flush_i;
            end
            default: begin
                start_int = 1'b0;
            end
        endcase
    end

    // Destination latch on accept, timeout counting and result capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            rd_we_q   <= 1'b0;
            rd_addr_q <= 5'd0;
            rd_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        rd_addr_q <= id_rd_addr_i;
                        rd_we_q   <= id_rd_we_i;
                    end
                end
                START: begin
                    cnt_q <= '0;
                end
                BUSY: begin
                    if (!flush_i) begin
                        if (mc.mc_done) begin
                            rd_data_q <= mc.mc_result;
                        end else if (!cnt_last) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    cnt_q <= cnt_q;
                end
            endcase
        end
    end

    assign mc.mc_start = start_int;
    assign mc.mc_kill  = kill_int;
    assign mc_err_o    = err_int;
    assign wb_valid_o  = wb_int;
    assign rd_we_o     = we_int;
    assign rd_addr_o   = rd_addr_q;
    assign rd_data_o   = rd_data_q;

endmodule
